feature_result_collector: RTL and testbench
===========================================

# feature_result_collector

Back-end consumer of the accelerator's dual-kernel result stream. Accepts the two 16-bit pooled feature channels (`din_bus`/`valid_in_bus`, same packing the pipeline top drives on `dout_bus`/`valid_out_bus`), buffers each channel in its own FIFO, and re-emits one 16-bit word at a time on a ready/valid stream, strictly interleaved ch0, ch1. Counts results per frame, pulses `frame_done` and flags overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: per-channel FIFO entries; power of two, ≥4.
- `CNT_W`, 16: width of result counters.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `start`  in  1  one-cycle pulse; arms collection of one frame.
- `result_count`  in  CNT_W  results expected per channel this frame; sampled on `start`.
- `din_bus`  in  32  `[15:0]` = ch0 value, `[31:16]` = ch1 value (signed).
- `valid_in_bus`  in  2  bit0 qualifies ch0, bit1 qualifies ch1; independent.
- `dout`  out  16  output word.
- `dout_ch`  out  1  channel of `dout` (0/1).
- `dout_valid`  out  1  `dout`/`dout_ch` valid.
- `dout_ready`  in  1  downstream accepts when `dout_valid && dout_ready`.
- `busy`  out  1  high in COLLECT.
- `frame_done`  out  1  one-cycle pulse after last word accepted.
- `overflow`  out  1  sticky: a push was dropped on a full FIFO.
- `stall_cycles`  out  CNT_W  perf counter (see Configuration).

## Operation
- States: IDLE, COLLECT.
- IDLE: `valid_in_bus` ignored (no push). `start` → latch `result_count` into `target`, clear `overflow`, both push counters, emit counter, `stall_cycles`; go COLLECT. `start` with `result_count`==0 → stay IDLE, pulse `frame_done` next cycle.
- COLLECT: each set bit of `valid_in_bus` pushes its channel value, but only while that channel's push count < `target`; extra inputs discarded silently (not overflow). Push to a full FIFO: data dropped, `overflow`←1, push count still increments.
- `start` in COLLECT ignored.
- Emission: `next_ch` toggle, starts 0. Output register loads from FIFO[`next_ch`] head when register empty or being accepted this cycle and that FIFO non-empty; then `next_ch` flips. Never skips a channel: ch1 empty blocks ch0.
- Emit counter increments per accepted word; on acceptance of word number 2·`target` → `frame_done` pulse next cycle, state IDLE, both FIFOs flushed.
- Handshake: once `dout_valid`=1, `dout`/`dout_ch` stable until accepted; `dout_valid` drops only after acceptance with nothing to reload.
- Reset mid-frame: FIFOs flushed, state IDLE, all outputs to reset values; no `frame_done`.

## Timing
- Reset values: `dout`=0, `dout_ch`=0, `dout_valid`=0, `busy`=0, `frame_done`=0, `overflow`=0, `stall_cycles`=0.
- `busy` rises the cycle after `start`.
- Latency: value pushed in cycle t appears on `dout` no earlier than cycle t+2 (FIFO count edge, then output-register edge).
- Throughput: one word/cycle with `dout_ready` held high and FIFOs non-empty.
- Simultaneous push and pop on same FIFO: both happen; full FIFO with simultaneous pop still rejects the push (full evaluated pre-pop).
- `frame_done` pulses in cycle after final acceptance; `busy` falls same cycle.

## Configuration
- `FEATURE_COLLECTOR_PERF_EN` defined: `stall_cycles` counts cycles in COLLECT with `dout_valid && !dout_ready`, saturating at all-ones, cleared on accepted `start`.
- Not defined: counter logic omitted, `stall_cycles` tied to 0.

## Structure
- `feature_collector_pkg`: state enum (IDLE, COLLECT), channel-id constants, default `FIFO_DEPTH`/`CNT_W`.
- Sub-module `result_fifo`: synchronous FWFT FIFO, 16-bit, parameterised depth, push/pop/flush, full/empty; instantiated twice.

## Test plan
- `result_count`=4, both channels valid 4 consecutive cycles with ch0=1..4, ch1=-1..-4, ready=1 → output 1,-1,2,-2,3,-3,4,-4, `dout_ch` 0,1,…; `frame_done` one pulse; `overflow`=0.
- Same, `dout_ready` toggling 1/0 → identical sequence, words stable while stalled; with PERF_EN `stall_cycles`= number of stalled valid cycles.
- `FIFO_DEPTH`=4, `result_count`=8, ready=0 for 10 cycles during input → `overflow`=1, first 4 words/channel plus in-flight output register delivered correctly.
- ch1 delayed 3 cycles relative to ch0 → output still strictly ch0,ch1 alternating.
- 6 valid inputs with `result_count`=4 → only first 4/channel emitted; `valid_in_bus` pulses in IDLE produce no output.
- `rst_n`=0 mid-frame after 3 words → all outputs reset values, no `frame_done`; subsequent `start` frame runs clean.

Source files
------------

// File: rtl/feature_collector_pkg.sv
// feature_collector_pkg: shared state type, channel ids and default sizes for feature_result_collector
package feature_collector_pkg;
    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: 16-bit synchronous first-word-fall-through FIFO with flush; full is judged before any same-cycle pop
module result_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop,
    input  logic        flush,
    output logic [15:0] rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    logic [15:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rd_q];
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        wr_d = flush ? '0 : wr_q + AW'(do_push);
        rd_d = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/feature_result_collector.sv
// feature_result_collector: buffers two pooled channels and re-emits them interleaved ch0,ch1 per frame.
// Define FEATURE_COLLECTOR_PERF_EN to build the stall_cycles performance counter.
module feature_result_collector
    import feature_collector_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] result_count,
    input  logic [31:0]      din_bus,
    input  logic [1:0]       valid_in_bus,
    output logic [15:0]      dout,
    output logic             dout_ch,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [CNT_W:0] EMIT_ONE = 1;
    state_t state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] push_cnt_q [2];
    logic [CNT_W-1:0] push_cnt_d [2];
    logic [CNT_W:0] emit_q, emit_d;
    logic [15:0] dout_q, dout_d;
    logic next_ch_q, next_ch_d, dout_ch_q, dout_ch_d, dout_valid_q, dout_valid_d;
    logic frame_done_q, frame_done_d, overflow_q, overflow_d;
    logic [1:0] push, pop, full, empty;
    logic [15:0] head [2];
    logic collect, arm, accept, last, load;
    for (genvar c = 0; c < 2; c++) begin : g_fifo
        result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk),
            .rst_n(rst_n),
            .push(push[c]),
            .wdata(din_bus[16*c +: 16]),
            .pop(pop[c]),
            .flush(last),
            .rdata(head[c]),
            .full(full[c]),
            .empty(empty[c])
        );
    end
    always_comb begin
        collect = state_q == COLLECT;
        arm = !collect && start;
        accept = dout_valid_q && dout_ready;
        last = collect && accept && (emit_q + EMIT_ONE == {target_q, 1'b0});
        // ch1 empty blocks ch0: the output register only ever takes the head of next_ch
        load = collect && !last && (!dout_valid_q || accept) && !empty[next_ch_q];
        pop[0] = load && next_ch_q == CH0;
        pop[1] = load && next_ch_q == CH1;
        for (int i = 0; i < 2; i++) begin
            push[i] = collect && valid_in_bus[i] && push_cnt_q[i] < target_q;
            push_cnt_d[i] = arm ? '0 : push_cnt_q[i] + CNT_W'(push[i]);
        end
        state_d = (arm && result_count != '0) ? COLLECT : last ? IDLE : state_q;
        target_d = arm ? result_count : target_q;
        emit_d = arm ? '0 : emit_q + (CNT_W+1)'(accept);
        overflow_d = !arm && (overflow_q || |(push & full));
        next_ch_d = arm ? CH0 : next_ch_q ^ load;
        dout_d = load ? head[next_ch_q] : dout_q;
        dout_ch_d = load ? next_ch_q : dout_ch_q;
        dout_valid_d = load || (dout_valid_q && !accept);
        frame_done_d = last || (arm && result_count == '0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            target_q <= '0;
            push_cnt_q <= '{default: '0};
            emit_q <= '0;
            overflow_q <= 1'b0;
            next_ch_q <= CH0;
            dout_q <= '0;
            dout_ch_q <= CH0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            target_q <= target_d;
            push_cnt_q <= push_cnt_d;
            emit_q <= emit_d;
            overflow_q <= overflow_d;
            next_ch_q <= next_ch_d;
            dout_q <= dout_d;
            dout_ch_q <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end
`ifdef FEATURE_COLLECTOR_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    always_comb begin
        stall_d = arm ? '0 : (collect && dout_valid_q && !dout_ready && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else stall_q <= stall_d;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
    assign busy = state_q == COLLECT;
    assign dout = dout_q;
    assign dout_ch = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_feature_result_collector.sv
// tb_feature_result_collector: directed frames with a scoreboard queue checked by an independent output monitor
module tb_feature_result_collector;
    localparam int CW = 16;
    logic clk = 0, rst_n = 0, start = 0, dout_ready = 0;
    logic [CW-1:0] result_count = 0;
    logic [31:0] din_bus = 0;
    logic [1:0] valid_in_bus = 0;
    logic [15:0] dout;
    logic dout_ch, dout_valid, busy, frame_done, overflow;
    logic [CW-1:0] stall_cycles;
    int checks = 0, failures = 0;
    int acc_cnt = 0, fd_cnt = 0, mon_stall = 0, stall_base = 0;
    int rdy_mode = 0;
    logic tog = 0, was_stall = 0;
    logic [16:0] held = 0;
    logic [16:0] sb [$];

    always #5 clk = ~clk;

    feature_result_collector #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .result_count(result_count),
        .din_bus(din_bus), .valid_in_bus(valid_in_bus), .dout(dout), .dout_ch(dout_ch),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0 = ready low, 1 = ready high, 2 = ready toggling every cycle
    always begin
        @(posedge clk);
        #2;
        tog = ~tog;
        dout_ready = rdy_mode == 2 ? tog : rdy_mode == 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (was_stall) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_word", {dout_ch, dout}, held);
            end
            if (frame_done) fd_cnt++;
            if (busy && dout_valid && !dout_ready) mon_stall++;
            if (dout_valid && dout_ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got ch%0d %0h expected none", dout_ch, dout);
                end else chk("word", {dout_ch, dout}, sb.pop_front());
            end
            was_stall = dout_valid && !dout_ready;
            held = {dout_ch, dout};
        end else was_stall = 0;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp(input logic ch, input logic [15:0] v);
        sb.push_back({ch, v});
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] a, input logic [15:0] b);
        valid_in_bus = v;
        din_bus = {b, a};
        step();
    endtask

    task automatic do_start(input int cnt);
        start = 1;
        result_count = CW'(cnt);
        step();
        start = 0;
        stall_base = mon_stall;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_dout"}, dout, 0);
        chk({name, "_dout_ch"}, dout_ch, 0);
        chk({name, "_dout_valid"}, dout_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_overflow"}, overflow, 0);
        chk({name, "_stall"}, stall_cycles, 0);
    endtask

    task automatic frame_check(input string name, input int fd0);
        int n = 0;
        while (fd_cnt == fd0 && n < 200) begin
            step();
            n++;
        end
        step(2);
        chk({name, "_frame_done_pulses"}, fd_cnt - fd0, 1);
        chk({name, "_words_left"}, sb.size(), 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_overflow"}, overflow, 0);
`ifdef FEATURE_COLLECTOR_PERF_EN
        chk({name, "_stall"}, stall_cycles, mon_stall - stall_base);
`else
        chk({name, "_stall"}, stall_cycles, 0);
`endif
    endtask

    task automatic basic_frame(input string name, input int mode, input int base);
        int fd0;
        rdy_mode = mode;
        step();
        fd0 = fd_cnt;
        do_start(4);
        chk({name, "_busy_rise"}, busy, 1);
        for (int i = 0; i < 4; i++) begin
            exp(0, 16'(base + i));
            exp(1, 16'(-(base + i)));
        end
        for (int i = 0; i < 4; i++) drive(2'b11, 16'(base + i), 16'(-(base + i)));
        valid_in_bus = 0;
        frame_check(name, fd0);
    endtask

    initial begin
        int fd0, acc0, n;
        step(3);
        chk_reset("reset");
        rst_n = 1;
        step();

        basic_frame("seq", 1, 1);
        basic_frame("toggle", 2, 1);

        fd0 = fd_cnt;
        do_start(0);
        chk("zero_busy", busy, 0);
        chk("zero_done_high", frame_done, 1);
        step();
        chk("zero_done_low", frame_done, 0);
        chk("zero_pulses", fd_cnt - fd0, 1);

        rdy_mode = 1;
        fd0 = fd_cnt;
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            exp(0, 16'(5 + i));
            exp(1, 16'(50 + i));
        end
        for (int i = 0; i < 7; i++) drive({i >= 3, i < 4}, 16'(5 + i), 16'(47 + i));
        valid_in_bus = 0;
        frame_check("ch1_delay", fd0);

        fd0 = fd_cnt;
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            exp(0, 16'(100 + i));
            exp(1, 16'(200 + i));
        end
        for (int i = 0; i < 6; i++) drive(2'b11, 16'(100 + i), 16'(200 + i));
        valid_in_bus = 0;
        frame_check("excess", fd0);

        for (int i = 0; i < 3; i++) drive(2'b11, 16'h7777, 16'h8888);
        valid_in_bus = 0;
        step(5);
        chk("idle_no_valid", dout_valid, 0);
        chk("idle_no_busy", busy, 0);

        rdy_mode = 0;
        step();
        fd0 = fd_cnt;
        do_start(8);
        exp(0, 10);
        for (int i = 0; i < 4; i++) begin
            exp(1, 16'(20 + i));
            exp(0, 16'(11 + i));
        end
        for (int i = 0; i < 8; i++) drive(2'b11, 16'(10 + i), 16'(20 + i));
        valid_in_bus = 0;
        step(2);
        rdy_mode = 1;
        step(20);
        chk("ovf_words_left", sb.size(), 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_no_done", fd_cnt - fd0, 0);
        rst_n = 0;
        step(2);
        chk_reset("ovf_reset");
        rst_n = 1;
        step();

        rdy_mode = 0;
        step();
        do_start(4);
        for (int i = 1; i <= 4; i++) begin
            exp(0, 16'(i));
            exp(1, 16'(-i));
        end
        for (int i = 1; i <= 4; i++) drive(2'b11, 16'(i), 16'(-i));
        valid_in_bus = 0;
        acc0 = acc_cnt;
        rdy_mode = 1;
        n = 0;
        while (acc_cnt - acc0 < 3 && n < 50) begin
            step();
            n++;
        end
        rst_n = 0;
        chk("midreset_accepted", acc_cnt - acc0, 3);
        chk("midreset_left", sb.size(), 5);
        sb.delete();
        fd0 = fd_cnt;
        step(2);
        chk_reset("midreset");
        rst_n = 1;
        step(4);
        chk("midreset_no_done", fd_cnt - fd0, 0);
        chk("midreset_idle_valid", dout_valid, 0);

        basic_frame("after_reset", 1, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
